// File: rtl/cell3_bist_ctrl_if.sv
// Signal bundle between the BIST controller and its cell-under-test harness.
// master = controller side (drives CUT inputs and results); slave = harness side.
interface cell3_bist_ctrl_if;
  logic       START;
  logic       ZN;
  logic       A1;
  logic       A2;
  logic       A3;
  logic       BUSY;
  logic       DONE;
  logic       PASS;
  logic [3:0] ERR_CNT;
  logic [2:0] FAIL_IDX;

  modport master (
    input  START, ZN,
    output A1, A2, A3, BUSY, DONE, PASS, ERR_CNT, FAIL_IDX
  );

  modport slave (
    output START, ZN,
    input  A1, A2, A3, BUSY, DONE, PASS, ERR_CNT, FAIL_IDX
  );
endinterface

// File: rtl/cell3_bist_ctrl.sv
// Exhaustive 3-input cell BIST: sweeps {A3,A2,A1} over 0..7 PASSES times, holding each
// vector SETTLE cycles before checking ZN against EXPECT_TT; reports PASS/ERR_CNT/FAIL_IDX.
module cell3_bist_ctrl #(
  parameter logic [7:0] EXPECT_TT = 8'h7F,
  parameter int         SETTLE    = 2,
  parameter int         PASSES    = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  cell3_bist_ctrl_if.master     bus,
  output logic [1:0]            dbg_state
);

  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("cell3_bist_ctrl: SETTLE must be in 1..15");
  end
  if (PASSES < 1 || PASSES > 4) begin : g_bad_passes
    $error("cell3_bist_ctrl: PASSES must be in 1..4");
  end

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [1:0] PASS_LAST   = 2'(PASSES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [2:0] vec, vec_n;
  logic [1:0] pass_cnt, pass_cnt_n;
  logic [3:0] settle_cnt, settle_cnt_n;
  logic [2:0] a_q, a_n;
  logic       busy_q, busy_n;
  logic       done_q, done_n;
  logic       pass_q, pass_n;
  logic [3:0] err_q, err_n;
  logic [2:0] fidx_q, fidx_n;
  logic       mismatch;
  logic [3:0] err_sample;

  // Case-equality so an X/Z response from the cell is never accepted as good.
  assign mismatch = !(bus.ZN === EXPECT_TT[vec]);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      vec        <= 3'd0;
      pass_cnt   <= 2'd0;
      settle_cnt <= 4'd0;
      a_q        <= 3'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= 4'd0;
      fidx_q     <= 3'd0;
    end else begin
      state      <= state_n;
      vec        <= vec_n;
      pass_cnt   <= pass_cnt_n;
      settle_cnt <= settle_cnt_n;
      a_q        <= a_n;
      busy_q     <= busy_n;
      done_q     <= done_n;
      pass_q     <= pass_n;
      err_q      <= err_n;
      fidx_q     <= fidx_n;
    end
  end

  always_comb begin
    state_n      = state;
    vec_n        = vec;
    pass_cnt_n   = pass_cnt;
    settle_cnt_n = settle_cnt;
    a_n          = a_q;
    busy_n       = busy_q;
    done_n       = done_q;
    pass_n       = pass_q;
    err_n        = err_q;
    fidx_n       = fidx_q;
    err_sample   = err_q;

    case (state)
      IDLE: begin
        if (bus.START) begin
          state_n      = DRIVE;
          vec_n        = 3'd0;
          pass_cnt_n   = 2'd0;
          settle_cnt_n = 4'd0;
          a_n          = 3'd0;
          err_n        = 4'd0;
          fidx_n       = 3'd0;
          done_n       = 1'b0;
          pass_n       = 1'b0;
          busy_n       = 1'b1;
        end
      end

      DRIVE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_n      = SAMPLE;
          settle_cnt_n = 4'd0;
        end else begin
          settle_cnt_n = settle_cnt + 4'd1;
        end
      end

      SAMPLE: begin
        if (mismatch) begin
          err_sample = (err_q == 4'd15) ? 4'd15 : err_q + 4'd1;
          if (err_q == 4'd0) fidx_n = vec;
        end
        err_n = err_sample;
        if (vec != 3'd7) begin
          vec_n   = vec + 3'd1;
          a_n     = vec + 3'd1;
          state_n = DRIVE;
        end else if (pass_cnt != PASS_LAST) begin
          vec_n      = 3'd0;
          a_n        = 3'd0;
          pass_cnt_n = pass_cnt + 2'd1;
          state_n    = DRIVE;
        end else begin
          // vec is left at 7; only the CUT inputs return to 0.
          state_n = IDLE;
          a_n     = 3'd0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          pass_n  = (err_sample == 4'd0);
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign bus.A1       = a_q[0];
  assign bus.A2       = a_q[1];
  assign bus.A3       = a_q[2];
  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;
  assign bus.PASS     = pass_q;
  assign bus.ERR_CNT  = err_q;
  assign bus.FAIL_IDX = fidx_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_cell3_bist_ctrl.sv
// Bench for cell3_bist_ctrl: table-driven CUT fault patterns, random CUT truth tables
// against a sweep-level reference model, and directed reset/START corner sequences.
module tb_cell3_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg1, dbg2;

  cell3_bist_ctrl_if bus();
  cell3_bist_ctrl_if bus2();

  cell3_bist_ctrl dut (
    .CLK(clk), .RST(rst), .bus(bus), .dbg_state(dbg1)
  );

  cell3_bist_ctrl #(.EXPECT_TT(8'h7F), .SETTLE(1), .PASSES(3)) dut2 (
    .CLK(clk), .RST(rst), .bus(bus2), .dbg_state(dbg2)
  );

  always #5 clk = ~clk;

  // CUT model: a truth table, optionally with an unknown response on vector 3
  logic [7:0] cut_tt = 8'h7F;
  logic       x_on   = 1'b0;
  logic       zn_x   = 1'bx;
  logic [7:0] exp_tt = 8'h7F;

  always_comb begin
    if (x_on && {bus.A3, bus.A2, bus.A1} == 3'd3) bus.ZN = zn_x;
    else                                          bus.ZN = cut_tt[{bus.A3, bus.A2, bus.A1}];
  end
  assign bus2.ZN = 1'b0;

  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: walk every sample of the run and tally mismatches directly
  task automatic ref_model(input logic [7:0] tt, input bit x3, input int passes,
                           output int err, output int fidx, output int ok);
    logic zn;
    err  = 0;
    fidx = 0;
    for (int p = 0; p < passes; p++) begin
      for (int v = 0; v < 8; v++) begin
        zn = (x3 && v == 3) ? zn_x : tt[v];
        if (!(zn === exp_tt[v])) begin
          if (err == 0) fidx = v;
          if (err < 15) err++;
        end
      end
    end
    ok = (err == 0) ? 1 : 0;
  endtask

  task automatic run_check(input string name, input logic [7:0] tt, input bit x3,
                           input bit pulses, input int exp_err, input int exp_fidx,
                           input int exp_pass);
    int k;
    int seq_bad;
    cut_tt = tt;
    x_on   = x3;
    @(negedge clk);
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    k = 0;
    seq_bad = 0;
    while (!bus.DONE && k < 200) begin
      if (k < 24) begin
        if ({bus.A3, bus.A2, bus.A1} != 3'(k / 3) || !bus.BUSY) seq_bad++;
      end
      bus.START = (pulses && (k == 5 || k == 12)) ? 1'b1 : 1'b0;
      step();
      k++;
    end
    bus.START = 1'b0;
    check({name, "_latency"}, k, 24);
    check({name, "_aseq_bad"}, seq_bad, 0);
    check({name, "_busy"}, int'(bus.BUSY), 0);
    check({name, "_a_idle"}, int'({bus.A3, bus.A2, bus.A1}), 0);
    check({name, "_err"}, int'(bus.ERR_CNT), exp_err);
    check({name, "_fidx"}, int'(bus.FAIL_IDX), exp_fidx);
    check({name, "_pass"}, int'(bus.PASS), exp_pass);
    step();
    check({name, "_done_hold"}, int'(bus.DONE), 1);
    x_on = 1'b0;
  endtask

  function automatic int all_outs();
    return int'({bus.A3, bus.A2, bus.A1, bus.BUSY, bus.DONE, bus.PASS,
                 bus.ERR_CNT, bus.FAIL_IDX, dbg1});
  endfunction

  typedef struct {
    logic [7:0] tt;
    bit         pulses;
    int         err;
    int         fidx;
    int         pass;
  } tv_t;

  tv_t tbl[5];

  initial begin
    int k, e, f, ok;
    logic [7:0] rtt;

    tbl[0] = '{8'h7F, 1'b0, 0, 0, 1};  // ideal nand3
    tbl[1] = '{8'hFF, 1'b0, 1, 7, 0};  // stuck-at-1
    tbl[2] = '{8'h00, 1'b0, 7, 0, 0};  // stuck-at-0
    tbl[3] = '{8'h77, 1'b0, 1, 3, 0};  // wrong only on vector 3
    tbl[4] = '{8'h7F, 1'b1, 0, 0, 1};  // START pulses while busy

    bus.START  = 1'b0;
    bus2.START = 1'b0;
    #1;
    check("reset_outs", all_outs(), 0);
    check("reset_outs2", int'({bus2.BUSY, bus2.DONE, bus2.PASS, bus2.ERR_CNT}), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      run_check($sformatf("tbl%0d", i), tbl[i].tt, 1'b0, tbl[i].pulses,
                tbl[i].err, tbl[i].fidx, tbl[i].pass);
    end

    ref_model(8'h7F, 1'b1, 1, e, f, ok);
    run_check("xvec3", 8'h7F, 1'b1, 1'b0, e, f, ok);

    for (int r = 0; r < 6; r++) begin
      rtt = 8'($urandom_range(0, 255));
      ref_model(rtt, 1'b0, 1, e, f, ok);
      run_check($sformatf("rand%0d", r), rtt, 1'b0, 1'b0, e, f, ok);
    end

    // Three sweeps at SETTLE=1 against stuck-at-0 saturate the error count
    @(negedge clk);
    bus2.START = 1'b1;
    step();
    bus2.START = 1'b0;
    k = 0;
    while (!bus2.DONE && k < 300) begin
      step();
      k++;
    end
    check("multi_latency", k, 48);
    check("multi_err", int'(bus2.ERR_CNT), 15);
    check("multi_fidx", int'(bus2.FAIL_IDX), 0);
    check("multi_pass", int'(bus2.PASS), 0);

    // Reset mid-run
    cut_tt = 8'h7F;
    @(negedge clk);
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("pre_rst_busy", int'(bus.BUSY), 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_outs", all_outs(), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (bus.DONE || bus.BUSY) k++;
    end
    check("post_rst_quiet", k, 0);
    run_check("after_rst", 8'h7F, 1'b0, 1'b0, 0, 0, 1);

    // START held high: back-to-back runs with a one-cycle DONE
    @(negedge clk);
    bus.START = 1'b1;
    step();
    k = 0;
    while (!bus.DONE && k < 200) begin
      step();
      k++;
    end
    check("held_lat1", k, 24);
    step();
    check("held_done_pulse", int'(bus.DONE), 0);
    check("held_restart", int'(bus.BUSY), 1);
    k = 1;
    while (!bus.DONE && k < 200) begin
      step();
      k++;
    end
    bus.START = 1'b0;
    check("held_lat2", k, 25);
    check("held_pass", int'(bus.PASS), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
